// File: rtl/image_pkg.sv
// Shared definitions for the pixel image store and dump paths.
// Dump sequencer states, framing characters and group size.
// Sextet-to-ASCII mapping shared by the base64 encoder and decoder tables.
package image_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] B64_PAD = 8'h3D;
   localparam logic [7:0] CR      = 8'h0D;
   localparam logic [7:0] LF      = 8'h0A;

   localparam int PIX_PER_GROUP = 12;

   // Standard base64 alphabet: A-Z, a-z, 0-9, '+', '/'.
   function automatic logic [7:0] b64_char(input logic [5:0] v);
      logic [7:0] c;
      if (v < 6'd26) begin
         c = 8'h41 + {2'b00, v};
      end else if (v < 6'd52) begin
         c = 8'h61 + {2'b00, v} - 8'd26;
      end else if (v < 6'd62) begin
         c = 8'h30 + {2'b00, v} - 8'd52;
      end else if (v == 6'd62) begin
         c = 8'h2B;
      end else begin
         c = 8'h2F;
      end
      return c;
   endfunction

endpackage

// File: rtl/b64_sextet_enc.sv
// Base64 sextet encoder: 6-bit value to its ASCII character.
// Latency: purely combinational.
// Backpressure: none, no state.
module b64_sextet_enc
   import image_pkg::*;
(
   input  logic [5:0] sextet,
   output logic [7:0] ascii
);

   assign ascii = b64_char(sextet);

endmodule

// File: rtl/image_b64_dump.sv
// Streams the stored 2bpp image as base64 ASCII: 12 pixels per group, 4 chars per group, '=' padding.
// Latency: start to first tx_valid is 12 + RD_LAT + 1 cycles; fetch and emit never overlap.
// Backpressure: tx_valid/tx_data held until tx_ready; CR LF every LINE_CHARS chars when B64_LINEBREAK_EN is defined.
module image_b64_dump
   import image_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int NUM_PIXELS = 16384,
   parameter int RD_LAT     = 1,
   parameter int LINE_CHARS = 76
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_ce,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [1:0]        mem_dout,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   // Pixel counters carry one extra bit so a full 2^ADDR_W image is representable.
   localparam int            CW   = ADDR_W + 1;
   localparam logic [CW-1:0] NPIX = CW'(NUM_PIXELS);
`ifdef B64_LINEBREAK_EN
   localparam bit LB_EN = 1'b1;
`else
   localparam bit LB_EN = 1'b0;
`endif

   state_t            state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mem_ce_q, mem_ce_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic [CW-1:0]     pix_q, pix_d;       // next address to issue
   logic [CW-1:0]     base_q, base_d;     // first address of the current group
   logic [3:0]        cap_q, cap_d;       // pixels captured into the group
   logic [23:0]       group_q, group_d;
   logic [RD_LAT-1:0] vld_q, vld_d;       // tracks read data in flight
   logic [1:0]        idx_q, idx_d;       // char slot being presented
   logic [1:0]        crlf_q, crlf_d;     // 0: data char, 1: CR shown, 2: LF shown
   logic [15:0]       line_q, line_d;

   logic [CW-1:0]     remain, issued;
   logic [3:0]        grp_k;
   logic [2:0]        n_data;
   logic              capture, last_cap, xfer, more, line_full;
   logic [1:0]        sel_idx;
   logic [5:0]        sel_sextet;
   logic [7:0]        enc_char, next_char;

   // Group sizing, read-data capture and selection of the next char's sextet.
   always_comb begin
      remain    = NPIX - base_q;
      grp_k     = (remain >= CW'(PIX_PER_GROUP)) ? 4'(PIX_PER_GROUP) : remain[3:0];
      issued    = pix_q - base_q;
      // Data chars = bytes + 1; the remaining slots of the 4 are padding.
      n_data    = 3'((grp_k + 4'd3) >> 2) + 3'd1;
      capture   = (state_q == FETCH) && vld_q[RD_LAT-1];
      last_cap  = capture && ((cap_q + 4'd1) == grp_k);
      xfer      = tx_valid_q && tx_ready;
      more      = (pix_q < NPIX);
      line_full = LB_EN && ((line_q + 16'd1) == 16'(LINE_CHARS));

      group_d = group_q;
      if (capture) begin
         if (cap_q == 4'd0) begin
            group_d = '0;
         end
         group_d[5'd23 - {cap_q, 1'b0} -: 2] = mem_dout;
      end

      // Entering EMIT shows slot 0; afterwards the next slot follows the current one.
      sel_idx    = (state_q == EMIT) ? (idx_q + 2'd1) : 2'd0;
      sel_sextet = group_d[23:18];
      case (sel_idx)
         2'd0:    sel_sextet = group_d[23:18];
         2'd1:    sel_sextet = group_d[17:12];
         2'd2:    sel_sextet = group_d[11:6];
         default: sel_sextet = group_d[5:0];
      endcase
   end

   b64_sextet_enc u_enc (
      .sextet (sel_sextet),
      .ascii  (enc_char)
   );

   assign next_char = ({1'b0, sel_idx} < n_data) ? enc_char : B64_PAD;

   // Dump sequencer: next state and next values of every registered output.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      mem_ce_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      pix_d      = pix_q;
      base_d     = base_q;
      cap_d      = cap_q;
      vld_d      = vld_q << 1;
      vld_d[0]   = mem_ce_q;
      idx_d      = idx_q;
      crlf_d     = crlf_q;
      line_d     = line_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = FETCH;
               busy_d     = 1'b1;
               base_d     = '0;
               cap_d      = '0;
               line_d     = '0;
               mem_ce_d   = 1'b1;
               mem_addr_d = '0;
               pix_d      = CW'(1);
            end
         end

         FETCH: begin
            if (issued < CW'(grp_k)) begin
               mem_ce_d   = 1'b1;
               mem_addr_d = pix_q[ADDR_W-1:0];
               pix_d      = pix_q + CW'(1);
            end
            if (capture) begin
               cap_d = cap_q + 4'd1;
            end
            if (last_cap) begin
               state_d    = EMIT;
               tx_valid_d = 1'b1;
               tx_data_d  = next_char;
               idx_d      = 2'd0;
               crlf_d     = 2'd0;
            end
         end

         EMIT: begin
            if (xfer) begin
               if (crlf_q == 2'd1) begin
                  tx_data_d = LF;
                  crlf_d    = 2'd2;
               end else if ((crlf_q == 2'd0) && line_full && !((idx_q == 2'd3) && !more)) begin
                  tx_data_d = CR;
                  crlf_d    = 2'd1;
                  line_d    = '0;
               end else begin
                  if (crlf_q == 2'd0) begin
                     line_d = line_q + 16'd1;
                  end
                  crlf_d = 2'd0;
                  if (idx_q == 2'd3) begin
                     tx_valid_d = 1'b0;
                     if (more) begin
                        state_d    = FETCH;
                        base_d     = pix_q;
                        cap_d      = '0;
                        mem_ce_d   = 1'b1;
                        mem_addr_d = pix_q[ADDR_W-1:0];
                        pix_d      = pix_q + CW'(1);
                     end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     idx_d     = idx_q + 2'd1;
                     tx_data_d = next_char;
                  end
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any dump in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mem_ce_q   <= 1'b0;
         mem_addr_q <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         pix_q      <= '0;
         base_q     <= '0;
         cap_q      <= '0;
         group_q    <= '0;
         vld_q      <= '0;
         idx_q      <= '0;
         crlf_q     <= '0;
         line_q     <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mem_ce_q   <= mem_ce_d;
         mem_addr_q <= mem_addr_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         pix_q      <= pix_d;
         base_q     <= base_d;
         cap_q      <= cap_d;
         group_q    <= group_d;
         vld_q      <= vld_d;
         idx_q      <= idx_d;
         crlf_q     <= crlf_d;
         line_q     <= line_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mem_ce   = mem_ce_q;
   assign mem_addr = mem_addr_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;

endmodule

// File: doc/image_b64_dump.md
Name: image_b64_dump

Overview:
Reads a stored 2-bit-per-pixel image out of the pixel SDPB read port and streams it as base64 ASCII characters to the UART transmit path for host readback. It is the inverse of the receive-side decode/store path.
- Fetches 12 pixels (24 bits) per group, splits the group into four sextets and emits four characters over a valid/ready byte handshake.
- Pads the final partial group with '='.

Parameters:
ADDR_W, 16, width of pixel memory address
NUM_PIXELS, 16384, pixels per dump (1..2^ADDR_W)
RD_LAT, 1, memory read latency in clk cycles (1 or 2)
LINE_CHARS, 76, characters per output line (used only with B64_LINEBREAK_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a dump at address 0
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last character is accepted
mem_ce  out  1  read enable to pixel memory
mem_addr  out  ADDR_W  read address
mem_dout  in  2  read data, valid RD_LAT cycles after a mem_ce cycle
tx_data  out  8  ASCII character to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts tx_data when high with tx_valid

Behaviour:
- Reset (also mid-dump): abort immediately; state IDLE; busy, done, mem_ce, tx_valid = 0; mem_addr, tx_data = 0; all counters cleared. No partial output resumes after reset.
- States:
  - IDLE: start=1 -> FETCH; rd_addr=0; busy=1. start is ignored in every state other than IDLE.
  - FETCH: assert mem_ce for k consecutive cycles, where k = min(12, NUM_PIXELS - rd_addr). Addresses increment by 1.
    - A RD_LAT-deep valid shift register captures mem_dout into the group register, MSB-first: pixel 0 goes to bits [23:22], pixel 11 to bits [1:0]. Unfilled positions are 0.
    - When all k pixels are captured -> EMIT.
  - EMIT: present chars c0..c(n-1) with tx_valid=1. tx_data is held stable until tx_ready.
    - Sextet i = group[23-6i -: 6].
    - Full group (k=12): 4 chars.
    - Partial group: bytes b = ceil(k/4). b=3: 4 chars. b=2: 3 chars + '='. b=1: 2 chars + '=='.
    - After the last char is accepted: more pixels remain -> FETCH, otherwise -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Sextet mapping: 0-25 -> 'A'+v; 26-51 -> 'a'+(v-26); 62 -> '+'; 63 -> '/'. Pad char is 8'h3D.
- Handshake: a transfer occurs on a clk edge with tx_valid && tx_ready.
  - tx_valid never drops without a transfer.
  - The next char may be presented in the cycle after the transfer, giving 1 char/cycle maximum.
- Output length: 4*ceil(NUM_PIXELS/12) chars, plus line breaks when enabled.
- Latency:
  - start to first tx_valid = 12 + RD_LAT + 1 cycles for a full group.
  - FETCH does not overlap EMIT.
- The memory is read-only from this block. Arbitration against LCD reads is outside this block.

Optional Feature:
Macro B64_LINEBREAK_EN.
- Defined: after every LINE_CHARS-th emitted base64/pad char, CR (8'h0D) then LF (8'h0A) are emitted through the same handshake.
  - No CR LF follows the final char of the dump.
  - The line counter resets at start.
- Undefined: no line breaks; LINE_CHARS is unused. Output is a single continuous base64 string.

Decomposition:
- Shared package image_pkg:
  - state enum (IDLE, FETCH, EMIT, DONE)
  - B64_PAD = 8'h3D, CR = 8'h0D, LF = 8'h0A
  - PIX_PER_GROUP = 12
  - the sextet-to-ASCII function, shared with the decoder's table for consistency.
- Sub-module b64_sextet_enc: combinational 6-bit to 8-bit ASCII, instantiated once on the selected sextet.

Test Plan:
1. NUM_PIXELS=12, memory = 1,0,3,1,1,2,0,1,1,2,3,2, tx_ready=1 -> chars "TWFu", then done pulse; busy low afterwards.
2. NUM_PIXELS=16, pixels 0-11 = 0, pixels 12-15 = 1,0,3,1 -> "AAAATQ==" (8 chars), done once.
3. NUM_PIXELS=20, pixels 0-11 = 0, pixels 12-19 = 1,0,3,1,1,2,0,1 -> "AAAATWE=".
4. Backpressure: scenario 1 with tx_ready low for 5 cycles while 'W' is presented -> tx_data=8'h57 held stable, tx_valid stays high, no char lost or duplicated. Repeat with RD_LAT=2 -> same output.
5. Reset asserted during EMIT of scenario 2, then start again -> outputs zero in the cycle after reset; new dump emits the full "AAAATQ==". A start pulse while busy is ignored.
6. With B64_LINEBREAK_EN, LINE_CHARS=4, NUM_PIXELS=24, all pixels 3 -> "////", 0D, 0A, "////"; no trailing CR LF.
